// File: rtl/arith_pkg.sv
// Shared encodings for the arithmetic datapath sequencer: operation codes,
// error codes and the controller state enum.
package arith_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_e;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_OVF  = 2'd1;
   localparam logic [1:0] ERR_DIV0 = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_EXEC      = 3'd1,
      ST_DIV_ISSUE = 3'd2,
      ST_DIV_ARM   = 3'd3,
      ST_DIV_WAIT  = 3'd4,
      ST_DONE      = 3'd5
   } state_e;

endpackage

// File: rtl/arith_timeout_cnt.sv
// Cycle counter with clear/enable; expired is high on the LIMIT-th
// consecutive enabled cycle since the last clear.
module arith_timeout_cnt #(
   parameter int unsigned LIMIT = 63
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/arith_seq_ctrl.sv
// Sequencer for the shared add/sub/mul/div datapath. Define
// ARITH_SEQ_DIV_TIMEOUT_EN to bound the wait for div_ready (err_code 3).
module arith_seq_ctrl
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH       = 6,
   parameter int unsigned DIV_TIMEOUT = 63
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic               sign,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [WIDTH-1:0]   opa,
   output logic [WIDTH-1:0]   opb,
   input  logic [WIDTH-1:0]   add_sum,
   input  logic [WIDTH-1:0]   sub_rem,
   input  logic               add_ovf,
   input  logic               sub_ovf,
   input  logic [2*WIDTH-1:0] mul_prod,
   output logic               div_start,
   output logic               div_sign,
   input  logic [WIDTH-1:0]   div_q,
   input  logic [WIDTH-1:0]   div_r,
   input  logic               div_ready
);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
   logic               div_sign_q, div_sign_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic [1:0]         err_code_q, err_code_d;
   logic               tmo_expired;

`ifdef ARITH_SEQ_DIV_TIMEOUT_EN
   arith_timeout_cnt #(
      .LIMIT (DIV_TIMEOUT)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q != ST_DIV_WAIT),
      .en      (state_q == ST_DIV_WAIT),
      .expired (tmo_expired)
   );
`else
   logic unused_div_timeout;
   assign unused_div_timeout = ^DIV_TIMEOUT;
   assign tmo_expired        = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      div_sign_d = div_sign_q;
      result_d   = result_q;
      err_code_d = err_code_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d       = op_e'(op);
               opa_d      = a;
               opb_d      = b;
               div_sign_d = sign;
               // Divide-by-zero goes through EXEC so it shares the 2-cycle latency.
               state_d    = (op_e'(op) == OP_DIV && b != '0) ? ST_DIV_ISSUE : ST_EXEC;
            end
         end
         ST_EXEC: begin
            unique case (op_q)
               OP_ADD: begin
                  result_d   = {{WIDTH{1'b0}}, add_sum};
                  err_code_d = add_ovf ? ERR_OVF : ERR_NONE;
               end
               OP_SUB: begin
                  result_d   = {{WIDTH{1'b0}}, sub_rem};
                  err_code_d = sub_ovf ? ERR_OVF : ERR_NONE;
               end
               OP_MUL: begin
                  result_d   = mul_prod;
                  err_code_d = ERR_NONE;
               end
               OP_DIV: begin
                  result_d   = '0;
                  err_code_d = ERR_DIV0;
               end
               default: ;
            endcase
            state_d = ST_DONE;
         end
         ST_DIV_ISSUE: state_d = ST_DIV_ARM;
         ST_DIV_ARM:   state_d = ST_DIV_WAIT;
         ST_DIV_WAIT: begin
            if (div_ready) begin
               result_d   = {div_r, div_q};
               err_code_d = ERR_NONE;
               state_d    = ST_DONE;
            end else if (tmo_expired) begin
               result_d   = '0;
               err_code_d = ERR_TMO;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_ADD;
         opa_q      <= '0;
         opb_q      <= '0;
         div_sign_q <= 1'b0;
         result_q   <= '0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         div_sign_q <= div_sign_d;
         result_q   <= result_d;
         err_code_q <= err_code_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign div_start = (state_q == ST_DIV_ISSUE);
   assign div_sign  = div_sign_q;
   assign opa       = opa_q;
   assign opb       = opb_q;
   assign result    = result_q;
   assign err_code  = err_code_q;
   assign err       = (err_code_q != ERR_NONE);

endmodule

// File: tb/tb_arith_seq_ctrl.sv
// Directed bench for arith_seq_ctrl with simple adder/subtractor/multiplier
// and fixed-latency divider models driving the unit-result inputs.
module tb_arith_seq_ctrl;

   localparam int unsigned W = 6;

   logic           clk, rst, start, sign;
   logic [1:0]     op;
   logic [W-1:0]   a, b;
   logic           busy, done, err, div_start, div_sign, div_ready;
   logic [2*W-1:0] result, mul_prod;
   logic [1:0]     err_code;
   logic [W-1:0]   opa, opb, add_sum, sub_rem, div_q, div_r;
   logic           add_ovf, sub_ovf;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;
   int n_dstart = 0;

   arith_seq_ctrl #(
      .WIDTH       (6),
      .DIV_TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .sign      (sign),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .err       (err),
      .err_code  (err_code),
      .opa       (opa),
      .opb       (opb),
      .add_sum   (add_sum),
      .sub_rem   (sub_rem),
      .add_ovf   (add_ovf),
      .sub_ovf   (sub_ovf),
      .mul_prod  (mul_prod),
      .div_start (div_start),
      .div_sign  (div_sign),
      .div_q     (div_q),
      .div_r     (div_r),
      .div_ready (div_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath unit models: unsigned carry/borrow flag as overflow.
   assign {add_ovf, add_sum} = {1'b0, opa} + {1'b0, opb};
   assign {sub_ovf, sub_rem} = {1'b0, opa} - {1'b0, opb};
   assign mul_prod           = {6'd0, opa} * {6'd0, opb};

   // Divider model: ready pulses div_lat cycles after seeing div_start; not reset.
   int unsigned  div_lat  = 8;
   bit           div_hold = 1'b0;
   int unsigned  dcnt     = 0;
   logic         mdl_ready = 1'b0;
   logic [W-1:0] mdl_q = '0, mdl_r = '0;

   always @(posedge clk) begin
      mdl_ready <= 1'b0;
      if (div_start === 1'b1) begin
         dcnt  <= div_lat;
         mdl_q <= opa / opb;
         mdl_r <= opa % opb;
      end else if (dcnt > 0) begin
         dcnt <= dcnt - 1;
         if (dcnt == 1 && !div_hold) mdl_ready <= 1'b1;
      end
   end

   assign div_ready = mdl_ready;
   assign div_q     = mdl_q;
   assign div_r     = mdl_r;

   always @(negedge clk) begin
      if (done === 1'b1)      n_done++;
      if (div_start === 1'b1) n_dstart++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive a request at a negedge; returns at the negedge after the accepting edge.
   task automatic req(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic sg);
      start = 1'b1;
      op    = o;
      a     = va;
      b     = vb;
      sign  = sg;
      @(negedge clk);
      start = 1'b0;
   endtask

   int  ds0, dn0;
   bit  seen;

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'd0; sign = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_opa", opa, 0);
      chk("rst_opb", opb, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_div_sign", div_sign, 0);
      rst = 1'b0;
      @(negedge clk);

      // add 63+1 wraps with carry
      req(2'd0, 6'd63, 6'd1, 1'b0);
      chk("add_busy", busy, 1);
      chk("add_done_early", done, 0);
      chk("add_opa", opa, 63);
      chk("add_opb", opb, 1);
      @(negedge clk);
      chk("add_done", done, 1);
      chk("add_result", result, 0);
      chk("add_err", err, 1);
      chk("add_err_code", err_code, 1);
      @(negedge clk);
      chk("add_done_pulse", done, 0);
      chk("add_idle", busy, 0);
      chk("add_hold_code", err_code, 1);

      // back-to-back sub 5-9 borrows
      req(2'd1, 6'd5, 6'd9, 1'b0);
      @(negedge clk);
      chk("sub_b_done", done, 1);
      chk("sub_b_result", result, 60);
      chk("sub_b_err_code", err_code, 1);
      @(negedge clk);

      // sub 9-5 no borrow
      req(2'd1, 6'd9, 6'd5, 1'b0);
      @(negedge clk);
      chk("sub_result", result, 4);
      chk("sub_err", err, 0);
      chk("sub_err_code", err_code, 0);
      @(negedge clk);

      // mul 63*63
      ds0 = n_dstart;
      req(2'd2, 6'd63, 6'd63, 1'b0);
      @(negedge clk);
      chk("mul_done", done, 1);
      chk("mul_result", result, 3969);
      chk("mul_err", err, 0);
      @(negedge clk);
      chk("mul_no_div_start", n_dstart - ds0, 0);

      // divide by zero
      ds0 = n_dstart;
      req(2'd3, 6'd10, 6'd0, 1'b1);
      chk("dz_busy", busy, 1);
      chk("dz_div_start", div_start, 0);
      chk("dz_div_sign", div_sign, 1);
      @(negedge clk);
      chk("dz_done", done, 1);
      chk("dz_result", result, 0);
      chk("dz_err", err, 1);
      chk("dz_err_code", err_code, 2);
      @(negedge clk);
      chk("dz_no_div_start", n_dstart - ds0, 0);

      // divide 45/7 with an ignored start during the wait
      ds0 = n_dstart;
      dn0 = n_done;
      req(2'd3, 6'd45, 6'd7, 1'b0);
      chk("div_start_pulse", div_start, 1);
      chk("div_sign_lat", div_sign, 0);
      @(negedge clk);
      chk("div_start_drop", div_start, 0);
      @(negedge clk);
      chk("div_wait_busy", busy, 1);
      req(2'd0, 6'd1, 6'd1, 1'b1);
      chk("div_opa_held", opa, 45);
      chk("div_opb_held", opb, 7);
      chk("div_sign_held", div_sign, 0);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (done === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      chk("div_done_seen", seen, 1);
      chk("div_result", result, 198);
      chk("div_err", err, 0);
      chk("div_err_code", err_code, 0);
      repeat (3) @(negedge clk);
      chk("div_one_done", n_done - dn0, 1);
      chk("div_one_start", n_dstart - ds0, 1);
      chk("div_idle", busy, 0);

      // reset mid-divide, then stale ready must not complete anything
      req(2'd3, 6'd45, 6'd7, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_div_start", div_start, 0);
      chk("mrst_div_sign", div_sign, 0);
      chk("mrst_result", result, 0);
      chk("mrst_err", err, 0);
      chk("mrst_err_code", err_code, 0);
      chk("mrst_opa", opa, 0);
      chk("mrst_opb", opb, 0);
      @(negedge clk);
      rst = 1'b0;
      dn0 = n_done;
      repeat (12) @(negedge clk);
      chk("stale_no_done", n_done - dn0, 0);
      chk("stale_idle", busy, 0);

      // divider that never answers
      div_hold = 1'b1;
      req(2'd3, 6'd45, 6'd7, 1'b0);
`ifdef ARITH_SEQ_DIV_TIMEOUT_EN
      repeat (5) @(negedge clk);
      chk("tmo_not_yet", done, 0);
      chk("tmo_busy", busy, 1);
      @(negedge clk);
      chk("tmo_done", done, 1);
      chk("tmo_result", result, 0);
      chk("tmo_err", err, 1);
      chk("tmo_err_code", err_code, 3);
      @(negedge clk);
      chk("tmo_idle", busy, 0);
`else
      dn0 = n_done;
      repeat (20) @(negedge clk);
      chk("hang_busy", busy, 1);
      chk("hang_no_done", n_done - dn0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("hang_recover", busy, 0);
`endif
      div_hold = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
